// File: rtl/sti_load_scheduler_if.sv
// Requester handshakes, serializer strobe and the pi_* word descriptor bus
// between the word producers, the load scheduler and the STI.
interface sti_load_scheduler_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_data;
    logic [4:0]  req0_cfg;
    logic        req0_last;
    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_data;
    logic [4:0]  req1_cfg;
    logic        req1_last;
    logic        so_valid;
    logic        load;
    logic [15:0] pi_data;
    logic [1:0]  pi_length;
    logic        pi_fill;
    logic        pi_msb;
    logic        pi_low;
    logic        pi_end;

    modport slave (
        input  req0_valid, req0_data, req0_cfg, req0_last,
        input  req1_valid, req1_data, req1_cfg, req1_last,
        input  so_valid,
        output req0_ready, req1_ready,
        output load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end
    );

    modport master (
        output req0_valid, req0_data, req0_cfg, req0_last,
        output req1_valid, req1_data, req1_cfg, req1_last,
        output so_valid,
        input  req0_ready, req1_ready,
        input  load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end
    );
endinterface

// File: rtl/sti_load_scheduler.sv
// Round-robin word scheduler in front of the STI serializer: grants one
// descriptor, pulses load, counts so_valid strobes to word end, flags stream end.
//
// state | meaning
// IDLE  | arbitrate; grant a valid requester and capture its descriptor
// LOAD  | one-cycle load pulse to the STI, bit counter cleared
// SHIFT | count so_valid strobes until the word length, watchdog running
// GAP   | GAP idle cycles before the next arbitration
// DONE  | last word finished; terminal until reset
module sti_load_scheduler #(
    parameter int unsigned GAP  = 1,
    parameter int unsigned WDOG = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    sti_load_scheduler_if.slave   bus,
    output logic                  busy,
    output logic                  grant_id,
    output logic [7:0]            word_cnt,
    output logic                  err
);
    localparam int unsigned      WDW      = $clog2(WDOG + 1);
    localparam logic [WDW-1:0]   WD_LAST  = WDW'(WDOG - 1);
    localparam logic [3:0]       GAP_INIT = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SHIFT, S_GAP, S_DONE
    } state_t;

    state_t         state, state_nxt, after_word;
    logic           ptr;
    logic           last_r;
    logic [5:0]     bcnt;
    logic [WDW-1:0] wd;
    logic [3:0]     gcnt;
    logic [15:0]    pi_data_r;
    logic [1:0]     pi_length_r;
    logic           pi_fill_r, pi_msb_r, pi_low_r, pi_end_r;

    logic           grant, gnt_idx, ready0, ready1, load_c;
    logic           word_done, wd_expire;
    logic [2:0]     len_plus1;
    logic [5:0]     bits_exp;
    logic [15:0]    sel_data;
    logic [4:0]     sel_cfg;
    logic           sel_last;

    assign len_plus1  = {1'b0, pi_length_r} + 3'd1;
    assign bits_exp   = {len_plus1, 3'b000};
    assign after_word = (GAP == 0) ? S_IDLE : S_GAP;

    assign sel_data = gnt_idx ? bus.req1_data : bus.req0_data;
    assign sel_cfg  = gnt_idx ? bus.req1_cfg  : bus.req0_cfg;
    assign sel_last = gnt_idx ? bus.req1_last : bus.req0_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        gnt_idx   = 1'b0;
        ready0    = 1'b0;
        ready1    = 1'b0;
        load_c    = 1'b0;
        word_done = 1'b0;
        wd_expire = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    grant     = 1'b1;
                    // ptr only matters when both requesters compete
                    gnt_idx   = bus.req1_valid && (!bus.req0_valid || ptr);
                    ready0    = !gnt_idx;
                    ready1    = gnt_idx;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                load_c    = 1'b1;
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (bus.so_valid) begin
                    if (bcnt + 6'd1 == bits_exp) begin
                        word_done = 1'b1;
                        state_nxt = last_r ? S_DONE : after_word;
                    end
                end else if (wd >= WD_LAST) begin
                    wd_expire = 1'b1;
                    state_nxt = after_word;
                end
            end
            S_GAP: begin
                if (gcnt == 4'd0) state_nxt = S_IDLE;
            end
            S_DONE: state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr         <= 1'b0;
            last_r      <= 1'b0;
            grant_id    <= 1'b0;
            pi_data_r   <= '0;
            pi_length_r <= '0;
            pi_fill_r   <= 1'b0;
            pi_msb_r    <= 1'b0;
            pi_low_r    <= 1'b0;
            pi_end_r    <= 1'b0;
            bcnt        <= '0;
            wd          <= '0;
            gcnt        <= '0;
            word_cnt    <= '0;
            err         <= 1'b0;
        end else begin
            if (grant) begin
                ptr         <= ~gnt_idx;
                grant_id    <= gnt_idx;
                last_r      <= sel_last;
                pi_data_r   <= sel_data;
                pi_length_r <= sel_cfg[4:3];
                pi_fill_r   <= sel_cfg[2];
                pi_msb_r    <= sel_cfg[1];
                pi_low_r    <= sel_cfg[0];
                // registered here so it is already high during the load cycle
                pi_end_r    <= pi_end_r | sel_last;
            end
            if (state == S_LOAD) begin
                bcnt <= '0;
                wd   <= WDW'(1);
            end else if (state == S_SHIFT) begin
                if (bus.so_valid) begin
                    bcnt <= bcnt + 6'd1;
                    wd   <= WDW'(1);
                end else begin
                    wd   <= wd + WDW'(1);
                end
            end
            if (state == S_GAP) gcnt <= gcnt - 4'd1;
            else                gcnt <= GAP_INIT;
            if (word_done) word_cnt <= word_cnt + 8'd1;
            if (wd_expire) err <= 1'b1;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.load       = load_c;
    assign bus.pi_data    = pi_data_r;
    assign bus.pi_length  = pi_length_r;
    assign bus.pi_fill    = pi_fill_r;
    assign bus.pi_msb     = pi_msb_r;
    assign bus.pi_low     = pi_low_r;
    assign bus.pi_end     = pi_end_r;
    assign busy           = (state != S_IDLE) && (state != S_DONE);
endmodule
